// File: rtl/round_to_nearest_even_if.sv
// Bundle for the round-to-nearest-even decision: the operand bits to be rounded
// plus the combinational and registered rounding results.
interface round_to_nearest_even_if #(
    parameter int TRAIL = 2,
    parameter int CNT_W = 32
);
    logic             inValid;
    logic             keepBit;
    logic [TRAIL-1:0] trailingBits;
    logic             stickyBit;
    logic             roundDown;
    logic             inexact;
    logic             tie;
    logic             roundDownQ;
    logic             inexactQ;
    logic             tieQ;
    logic             outValid;
    logic [CNT_W-1:0] inexactCount;

    modport master (
        output inValid, keepBit, trailingBits, stickyBit,
        input  roundDown, inexact, tie,
        input  roundDownQ, inexactQ, tieQ, outValid, inexactCount
    );

    modport slave (
        input  inValid, keepBit, trailingBits, stickyBit,
        output roundDown, inexact, tie,
        output roundDownQ, inexactQ, tieQ, outValid, inexactCount
    );
endinterface

// File: rtl/round_to_nearest_even.sv
// IEEE-754 round-to-nearest, ties-to-even increment decision for a truncated
// significand, with a registered copy and a saturating inexact-event counter.
module round_to_nearest_even #(
    parameter int TRAIL = 2,
    parameter int CNT_W = 32
) (
    input logic                     clock,
    input logic                     reset,
    round_to_nearest_even_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // orChain[n] = stickyBit OR trailingBits[n-1:0]; the top entry covers all
    // bits below the guard, and degenerates to stickyBit when TRAIL is 1.
    logic [TRAIL-1:0] orChain;
    logic             guardBit;
    logic             restBit;
    logic             roundUp;
    logic             inexactComb;
    logic             tieComb;

    assign orChain[0] = bus.stickyBit;

    generate
        for (genvar gi = 0; gi < TRAIL - 1; gi++) begin : g_rest_or
            assign orChain[gi+1] = orChain[gi] | bus.trailingBits[gi];
        end
    endgenerate

    assign guardBit    = bus.trailingBits[TRAIL-1];
    assign restBit     = orChain[TRAIL-1];
    assign roundUp     = guardBit & (restBit | bus.keepBit);
    assign inexactComb = guardBit | restBit;
    assign tieComb     = guardBit & ~restBit;

    assign bus.roundDown = ~roundUp;
    assign bus.inexact   = inexactComb;
    assign bus.tie       = tieComb;

    logic             outValidReg;
    logic             roundDownReg;
    logic             inexactReg;
    logic             tieReg;
    logic [CNT_W-1:0] countReg;
    logic             roundDownNext;
    logic             inexactNext;
    logic             tieNext;
    logic [CNT_W-1:0] countNext;

    always_comb begin
        roundDownNext = roundDownReg;
        inexactNext   = inexactReg;
        tieNext       = tieReg;
        countNext     = countReg;
        if (bus.inValid) begin
            roundDownNext = ~roundUp;
            inexactNext   = inexactComb;
            tieNext       = tieComb;
            // Saturate rather than wrap so a long run never reads as "few events".
            if (inexactComb && (countReg != CNT_MAX)) begin
                countNext = countReg + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            outValidReg  <= 1'b0;
            roundDownReg <= 1'b1;
            inexactReg   <= 1'b0;
            tieReg       <= 1'b0;
            countReg     <= '0;
        end else begin
            outValidReg  <= bus.inValid;
            roundDownReg <= roundDownNext;
            inexactReg   <= inexactNext;
            tieReg       <= tieNext;
            countReg     <= countNext;
        end
    end

    assign bus.outValid     = outValidReg;
    assign bus.roundDownQ   = roundDownReg;
    assign bus.inexactQ     = inexactReg;
    assign bus.tieQ         = tieReg;
    assign bus.inexactCount = countReg;
endmodule

// File: tb/tb_round_to_nearest_even.sv
// Directed bench for round_to_nearest_even: truth-table sweep, ties, pipeline
// timing, reset collision and counter saturation.
module tb_round_to_nearest_even;
    logic clock;
    logic reset;
    int   testsRun;
    int   testsFailed;

    round_to_nearest_even_if #(.TRAIL(2), .CNT_W(32)) busA ();
    round_to_nearest_even_if #(.TRAIL(2), .CNT_W(3))  busS ();

    round_to_nearest_even #(.TRAIL(2), .CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (busA)
    );

    round_to_nearest_even #(.TRAIL(2), .CNT_W(3)) dutSat (
        .clock (clock),
        .reset (reset),
        .bus   (busS)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic driveA(input logic v, input logic k, input logic [1:0] t, input logic s);
        busA.inValid      = v;
        busA.keepBit      = k;
        busA.trailingBits = t;
        busA.stickyBit    = s;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        driveA(1'b0, 1'b0, 2'b00, 1'b0);
        @(posedge clock); #1;
        testsRun++;
        if (busA.outValid !== 1'b0) begin
            $display("FAIL reset_outValid got %0b want 0", busA.outValid); testsFailed++;
        end
        testsRun++;
        if (busA.roundDownQ !== 1'b1) begin
            $display("FAIL reset_roundDownQ got %0b want 1", busA.roundDownQ); testsFailed++;
        end
        testsRun++;
        if ({busA.inexactQ, busA.tieQ} !== 2'b00) begin
            $display("FAIL reset_inexactQ_tieQ got %b want 00", {busA.inexactQ, busA.tieQ}); testsFailed++;
        end
        testsRun++;
        if (busA.inexactCount !== 32'd0) begin
            $display("FAIL reset_count got %0d want 0", busA.inexactCount); testsFailed++;
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Bit i of roundUpMask is 1 when {keepBit, trailingBits, stickyBit} == i rounds up.
    task automatic test_sweep();
        logic [15:0] roundUpMask;
        logic [3:0]  idx;
        logic        expRd, expInexact, expTie;
        roundUpMask = 16'hF0E0;
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            @(negedge clock);
            driveA(1'b0, idx[3], idx[2:1], idx[0]);
            #1;
            expRd      = ~roundUpMask[idx];
            expInexact = (idx[2:0] != 3'b000);
            expTie     = (idx[2:0] == 3'b100);
            testsRun++;
            if ({busA.roundDown, busA.inexact, busA.tie} !== {expRd, expInexact, expTie}) begin
                $display("FAIL sweep k=%0b t=%b s=%0b got rd/inx/tie=%b want %b",
                         idx[3], idx[2:1], idx[0],
                         {busA.roundDown, busA.inexact, busA.tie}, {expRd, expInexact, expTie});
                testsFailed++;
            end
        end
        @(posedge clock); #1;
        testsRun++;
        if (busA.inexactCount !== 32'd0 || busA.outValid !== 1'b0) begin
            $display("FAIL sweep_invalid_ignored count=%0d outValid=%0b want 0 0",
                     busA.inexactCount, busA.outValid);
            testsFailed++;
        end
    endtask

    task automatic test_ties();
        @(negedge clock);
        driveA(1'b1, 1'b0, 2'b10, 1'b0);
        #1;
        testsRun++;
        if ({busA.roundDown, busA.tie, busA.inexact} !== 3'b111) begin
            $display("FAIL tie_even got rd/tie/inx=%b want 111", {busA.roundDown, busA.tie, busA.inexact});
            testsFailed++;
        end
        @(negedge clock);
        driveA(1'b1, 1'b1, 2'b10, 1'b0);
        #1;
        testsRun++;
        if ({busA.roundDown, busA.tie, busA.inexact} !== 3'b011) begin
            $display("FAIL tie_odd got rd/tie/inx=%b want 011", {busA.roundDown, busA.tie, busA.inexact});
            testsFailed++;
        end
        @(posedge clock); #1;
        testsRun++;
        if (busA.inexactCount !== 32'd2) begin
            $display("FAIL tie_count got %0d want 2", busA.inexactCount); testsFailed++;
        end
    endtask

    task automatic test_exact();
        @(negedge clock);
        driveA(1'b1, 1'b1, 2'b00, 1'b0);
        #1;
        testsRun++;
        if ({busA.roundDown, busA.inexact, busA.tie} !== 3'b100) begin
            $display("FAIL exact_comb got rd/inx/tie=%b want 100", {busA.roundDown, busA.inexact, busA.tie});
            testsFailed++;
        end
        @(posedge clock); #1;
        testsRun++;
        if (busA.inexactCount !== 32'd2) begin
            $display("FAIL exact_count got %0d want 2", busA.inexactCount); testsFailed++;
        end
        testsRun++;
        if ({busA.outValid, busA.roundDownQ, busA.inexactQ, busA.tieQ} !== 4'b1100) begin
            $display("FAIL exact_regs got v/rd/inx/tie=%b want 1100",
                     {busA.outValid, busA.roundDownQ, busA.inexactQ, busA.tieQ});
            testsFailed++;
        end
    endtask

    task automatic test_pipeline();
        @(negedge clock);
        driveA(1'b1, 1'b1, 2'b11, 1'b0);
        @(posedge clock); #1;
        testsRun++;
        if ({busA.outValid, busA.roundDownQ, busA.inexactQ, busA.tieQ} !== 4'b1010) begin
            $display("FAIL pipe_cycle1 got v/rd/inx/tie=%b want 1010",
                     {busA.outValid, busA.roundDownQ, busA.inexactQ, busA.tieQ});
            testsFailed++;
        end
        @(negedge clock);
        driveA(1'b0, 1'b0, 2'b00, 1'b0);
        @(posedge clock); #1;
        testsRun++;
        if ({busA.outValid, busA.roundDownQ, busA.inexactQ} !== 3'b001) begin
            $display("FAIL pipe_cycle2_hold got v/rd/inx=%b want 001",
                     {busA.outValid, busA.roundDownQ, busA.inexactQ});
            testsFailed++;
        end
        testsRun++;
        if (busA.inexactCount !== 32'd3) begin
            $display("FAIL pipe_count got %0d want 3", busA.inexactCount); testsFailed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] stim [3];
        logic [2:0] expQ [3];
        stim[0] = 4'b0100; expQ[0] = 3'b111;   // {k,t,s} -> {rd,inx,tie}
        stim[1] = 4'b1100; expQ[1] = 3'b011;
        stim[2] = 4'b0010; expQ[2] = 3'b110;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            driveA(1'b1, stim[i][3], stim[i][2:1], stim[i][0]);
            @(posedge clock); #1;
            testsRun++;
            if ({busA.outValid, busA.roundDownQ, busA.inexactQ, busA.tieQ} !== {1'b1, expQ[i]}) begin
                $display("FAIL b2b_%0d got v/rd/inx/tie=%b want %b", i,
                         {busA.outValid, busA.roundDownQ, busA.inexactQ, busA.tieQ}, {1'b1, expQ[i]});
                testsFailed++;
            end
            @(negedge clock);
        end
        driveA(1'b0, 1'b0, 2'b00, 1'b0);
        testsRun++;
        if (busA.inexactCount !== 32'd6) begin
            $display("FAIL b2b_count got %0d want 6", busA.inexactCount); testsFailed++;
        end
    endtask

    task automatic test_reset_collision();
        @(negedge clock);
        driveA(1'b1, 1'b1, 2'b11, 1'b1);
        reset = 1'b1;
        @(posedge clock); #1;
        testsRun++;
        if ({busA.outValid, busA.roundDownQ, busA.inexactQ} !== 3'b010) begin
            $display("FAIL rstcol_regs got v/rd/inx=%b want 010",
                     {busA.outValid, busA.roundDownQ, busA.inexactQ});
            testsFailed++;
        end
        testsRun++;
        if (busA.inexactCount !== 32'd0) begin
            $display("FAIL rstcol_count got %0d want 0", busA.inexactCount); testsFailed++;
        end
        @(negedge clock);
        reset = 1'b0;
        driveA(1'b0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic test_saturation();
        int expCount;
        @(negedge clock);
        busS.inValid = 1'b1; busS.keepBit = 1'b0; busS.trailingBits = 2'b01; busS.stickyBit = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clock); #1;
            expCount = (n > 7) ? 7 : n;
            testsRun++;
            if (busS.inexactCount !== 3'(expCount)) begin
                $display("FAIL sat_%0d got %0d want %0d", n, busS.inexactCount, expCount);
                testsFailed++;
            end
        end
        @(negedge clock);
        busS.inValid = 1'b0;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b1;
        driveA(1'b0, 1'b0, 2'b00, 1'b0);
        busS.inValid = 1'b0; busS.keepBit = 1'b0; busS.trailingBits = 2'b00; busS.stickyBit = 1'b0;
        test_reset();
        test_sweep();
        test_ties();
        test_exact();
        test_pipeline();
        test_back_to_back();
        test_reset_collision();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/round_to_nearest_even.md
Name: round_to_nearest_even

Overview:
- Decides the IEEE-754 round-to-nearest, ties-to-even increment for a truncated significand.
- Inputs: the LSB kept in the result, the discarded trailing bits (guard first), and a sticky OR of all bits below them.
- Used by float rounders, e.g. a float round stage that adds !roundDown to {exponent, fraction}.
- Provides a zero-latency combinational decision plus a registered copy with valid and an inexact-event counter.

Parameters:
- TRAIL, 2: width of trailingBits; MSB is the guard bit, remaining bits are round bits; must be >= 1.
- CNT_W, 32: width of the inexact-event counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- inValid  in  1  qualifies the inputs for the registered path and the counter.
- keepBit  in  1  LSB of the retained fraction.
- trailingBits  in  TRAIL  discarded bits; [TRAIL-1] is the guard bit.
- stickyBit  in  1  OR of all bits below trailingBits.
- roundDown  out  1  combinational; 1 = truncate, 0 = increment by one ULP.
- inexact  out  1  combinational; any discarded bit set.
- tie  out  1  combinational; exact halfway case.
- roundDownQ  out  1  registered roundDown.
- inexactQ  out  1  registered inexact.
- tieQ  out  1  registered tie.
- outValid  out  1  registered inValid.
- inexactCount  out  CNT_W  saturating count of valid inexact inputs.

Behaviour:
- guard = trailingBits[TRAIL-1].
- rest = OR(trailingBits[TRAIL-2:0]) OR stickyBit; when TRAIL=1, rest = stickyBit.
- Round up iff guard AND (rest OR keepBit); roundDown = NOT of that.
- Resulting cases:
  - guard=0 -> roundDown=1, regardless of the other inputs.
  - guard=1 with rest=1 -> roundDown=0 (above halfway).
  - guard=1, rest=0 (tie) -> roundDown = !keepBit, i.e. round to even.
- inexact = guard OR rest.
- tie = guard AND NOT rest.
- Combinational outputs depend only on the current inputs: no latency, independent of clock, reset and inValid.
- Registered path has 1-cycle latency:
  - On each rising edge with reset=0: outValid <= inValid.
  - When inValid=1, roundDownQ/inexactQ/tieQ <= the current combinational values.
  - When inValid=0, those registers hold their previous values.
- Counter: on an edge with inValid=1 and inexact=1, inexactCount increments by 1. It saturates at 2^CNT_W-1 and does not wrap.
- Reset (synchronous; wins over inValid on the same edge):
  - outValid=0, roundDownQ=1, inexactQ=0, tieQ=0, inexactCount=0.
  - Reset asserted mid-stream discards the in-flight sample.
- No backpressure; a new sample may be accepted every cycle.

Test Plan:
- TRAIL=2: sweep all 16 combinations of keepBit/trailingBits/stickyBit.
  - roundDown=0 exactly for (k,t,s) = (1,10,0), (x,11,x), (x,10,1).
  - All other cases give roundDown=1.
- Ties: trailingBits=10, sticky=0.
  - keepBit=0 -> roundDown=1, tie=1, inexact=1.
  - keepBit=1 -> roundDown=0, tie=1, inexact=1.
- Exact input: trailingBits=00, sticky=0, keepBit=1 -> roundDown=1, inexact=0, tie=0; counter unchanged.
- Pipeline: drive inValid=1 with (1,11,0), then inValid=0 with (0,00,0).
  - Cycle+1: outValid=1, roundDownQ=0.
  - Cycle+2: outValid=0, roundDownQ held at 0.
- Reset: assert reset on the same edge as a valid inexact input.
  - Next cycle: outValid=0, roundDownQ=1, inexactCount=0.
- Saturation: CNT_W=3, drive 10 valid inexact samples -> inexactCount stops at 7.
